// File: rtl/reset_seq_pkg.sv
// -----------------------------------------------------------------------------
// reset_seq_pkg
// Shared definitions for the security reset sequencer and the monitors feeding
// it: sequencer state encodings, viol_req bit positions and the reset-vector
// fetch address (also used by the PoR/attestation monitor).
// -----------------------------------------------------------------------------
package reset_seq_pkg;

   // Sequencer states. The encodings are shared with the monitor logic.
   typedef enum logic [1:0] {
      ST_IDLE     = 2'b00,
      ST_ASSERT   = 2'b01,
      ST_WAIT_VEC = 2'b10
   } state_e;

   // Bit positions inside viol_req.
   localparam int VIOL_POR    = 0;   // PoR / attestation monitor kill output
   localparam int VIOL_ATOMIC = 1;   // atomicity violation
   localparam int VIOL_KEY    = 2;   // key access violation
   localparam int VIOL_DMA    = 3;   // DMA violation

   // Address the core fetches its reset vector from.
   localparam logic [15:0] RESET_HANDLER_ADDR = 16'hFFFE;

   // Episode counter increment that sticks at all-ones instead of wrapping.
   function automatic logic [7:0] sat_inc8(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

endpackage

// File: rtl/reset_seq_edge_detect.sv
// -----------------------------------------------------------------------------
// edge_detect
// Registers a bus of level signals and reports the bits that rose this cycle
// (current level high, previous level low). The history register clears on
// reset, so a bit already high when reset releases reads as a rising edge.
//
// Ports
//   clk_i   : clock, rising edge
//   rst_i   : synchronous active-high reset, clears the history register
//   d_i     : level inputs
//   rise_o  : one-cycle rising-edge flags, combinational from d_i
// -----------------------------------------------------------------------------
module edge_detect #(
   parameter int W = 4
) (
   input  logic         clk_i,
   input  logic         rst_i,
   input  logic [W-1:0] d_i,
   output logic [W-1:0] rise_o
);

   logic [W-1:0] d_q;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         d_q <= '0;
      end else begin
         d_q <= d_i;
      end
   end

   assign rise_o = d_i & ~d_q;

endmodule

// File: rtl/reset_seq.sv
// -----------------------------------------------------------------------------
// reset_seq
// Security reset sequencer. A rising edge on any violation request line starts
// a reset episode: sys_rst is held high for HOLD_CYCLES cycles, then the
// sequencer waits for the core to fetch its reset vector (pc == RESET_HANDLER).
// If the fetch does not appear within WAIT_TIMEOUT cycles the reset is
// re-issued and rst_timeout is flagged. A new violation while waiting also
// re-issues the reset.
//
// Ports
//   clk         : system clock, rising edge
//   reset       : synchronous active-high reset, aborts any episode
//   pc          : current MCU program counter
//   viol_req    : level violation requests (bit indices in reset_seq_pkg)
//   sys_rst     : registered reset to the MCU core
//   rst_cause   : violation bits of the current / last episode
//   rst_timeout : last episode hit the reset-vector wait timeout
//   viol_cnt    : saturating count of reset pulses issued
//   busy        : sequencer is not idle
// -----------------------------------------------------------------------------
module reset_seq
   import reset_seq_pkg::*;
#(
   parameter int          HOLD_CYCLES   = 8,
   parameter int          WAIT_TIMEOUT  = 256,
   parameter logic [15:0] RESET_HANDLER = RESET_HANDLER_ADDR,
   parameter int          NREQ          = 4
) (
   input  logic            clk,
   input  logic            reset,
   input  logic [15:0]     pc,
   input  logic [NREQ-1:0] viol_req,
   output logic            sys_rst,
   output logic [NREQ-1:0] rst_cause,
   output logic            rst_timeout,
   output logic [7:0]      viol_cnt,
   output logic            busy
);

   // The hold counter is loaded with HOLD_CYCLES-1 on entry to ASSERT and
   // leaves at zero, which gives exactly HOLD_CYCLES cycles of sys_rst.
   localparam logic [7:0]  HOLD_LOAD = 8'(HOLD_CYCLES - 1);
   localparam logic [15:0] WAIT_LAST = 16'(WAIT_TIMEOUT - 1);

   state_e          state_q;
   logic [7:0]      hold_q;
   logic [15:0]     wait_q;
   logic [NREQ-1:0] cause_q;
   logic            timeout_q;
   logic [7:0]      cnt_q;
   logic            sys_rst_q;
   logic            busy_q;

   logic [NREQ-1:0] event_d;
   logic [7:0]      cnt_d;
   logic            any_event_d;
   logic            pc_hit_d;

   // Only rising edges count, so a monitor that holds its kill line high
   // produces a single episode rather than an endless chain.
   edge_detect #(
      .W (NREQ)
   ) u_edge_detect (
      .clk_i  (clk),
      .rst_i  (reset),
      .d_i    (viol_req),
      .rise_o (event_d)
   );

   assign any_event_d = |event_d;
   assign pc_hit_d    = (pc == RESET_HANDLER);
   assign cnt_d       = sat_inc8(cnt_q);

   // Single-process FSM. sys_rst_q and busy_q are written alongside state_q
   // so they are always the registered decode of the state.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= ST_IDLE;
         hold_q    <= 8'd0;
         wait_q    <= 16'd0;
         cause_q   <= '0;
         timeout_q <= 1'b0;
         cnt_q     <= 8'd0;
         sys_rst_q <= 1'b0;
         busy_q    <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               // pc is ignored here; cause and timeout keep the last episode.
               if (any_event_d) begin
                  state_q   <= ST_ASSERT;
                  sys_rst_q <= 1'b1;
                  busy_q    <= 1'b1;
                  cause_q   <= event_d;
                  timeout_q <= 1'b0;
                  hold_q    <= HOLD_LOAD;
                  cnt_q     <= cnt_d;
               end
            end

            ST_ASSERT: begin
               // Late violations are recorded but neither extend the pulse
               // nor count as a new episode.
               cause_q <= cause_q | event_d;
               if (hold_q == 8'd0) begin
                  state_q   <= ST_WAIT_VEC;
                  sys_rst_q <= 1'b0;
                  wait_q    <= 16'd0;
               end else begin
                  hold_q <= hold_q - 8'd1;
               end
            end

            ST_WAIT_VEC: begin
               // A fresh violation wins over a simultaneous vector fetch.
               if (any_event_d) begin
                  state_q   <= ST_ASSERT;
                  sys_rst_q <= 1'b1;
                  cause_q   <= cause_q | event_d;
                  hold_q    <= HOLD_LOAD;
                  cnt_q     <= cnt_d;
               end else if (pc_hit_d) begin
                  state_q <= ST_IDLE;
                  busy_q  <= 1'b0;
               end else if (wait_q == WAIT_LAST) begin
                  // Core never reached the reset vector: reset it again,
                  // keeping the original cause.
                  state_q   <= ST_ASSERT;
                  sys_rst_q <= 1'b1;
                  timeout_q <= 1'b1;
                  hold_q    <= HOLD_LOAD;
                  cnt_q     <= cnt_d;
               end else begin
                  wait_q <= wait_q + 16'd1;
               end
            end

            default: begin
               state_q   <= ST_IDLE;
               sys_rst_q <= 1'b0;
               busy_q    <= 1'b0;
            end
         endcase
      end
   end

   assign sys_rst     = sys_rst_q;
   assign busy        = busy_q;
   assign rst_cause   = cause_q;
   assign rst_timeout = timeout_q;
   assign viol_cnt    = cnt_q;

endmodule

// File: tb/tb_reset_seq.sv
// -----------------------------------------------------------------------------
// tb_reset_seq
// Self-checking bench for reset_seq with default parameters. A behavioural
// model, written in terms of pulse cycles elapsed and wait cycles elapsed,
// is stepped on every clock and compared with all DUT outputs. On top of
// that, a vector table and a set of directed sequences check fixed values.
// -----------------------------------------------------------------------------
module tb_reset_seq;

   localparam int          HOLD = 8;
   localparam int          WT   = 256;
   localparam int          NREQ = 4;
   localparam logic [15:0] RH   = 16'hFFFE;
   localparam logic [15:0] PC0  = 16'h0100;

   logic            clk = 1'b0;
   logic            reset;
   logic [15:0]     pc;
   logic [NREQ-1:0] viol_req;
   logic            sys_rst;
   logic [NREQ-1:0] rst_cause;
   logic            rst_timeout;
   logic [7:0]      viol_cnt;
   logic            busy;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   reset_seq #(
      .HOLD_CYCLES   (HOLD),
      .WAIT_TIMEOUT  (WT),
      .RESET_HANDLER (RH),
      .NREQ          (NREQ)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .pc          (pc),
      .viol_req    (viol_req),
      .sys_rst     (sys_rst),
      .rst_cause   (rst_cause),
      .rst_timeout (rst_timeout),
      .viol_cnt    (viol_cnt),
      .busy        (busy)
   );

   // ---------------- behavioural model ----------------
   // m_mode: 0 idle, 1 pulsing, 2 waiting for the vector fetch.
   int              m_mode = 0;
   int              m_high = 0;     // sys_rst cycles produced so far this pulse
   int              m_waited = 0;   // cycles spent waiting so far
   logic [NREQ-1:0] m_prev = '0;
   logic [NREQ-1:0] m_cause = '0;
   logic            m_to = 1'b0;
   int              m_cnt = 0;

   task automatic m_new_pulse();
      m_mode = 1;
      m_high = 1;
      if (m_cnt < 255) m_cnt++;
   endtask

   task automatic model_step();
      logic [NREQ-1:0] ev;
      if (reset) begin
         m_mode = 0; m_high = 0; m_waited = 0;
         m_prev = '0; m_cause = '0; m_to = 1'b0; m_cnt = 0;
         return;
      end
      ev     = viol_req & ~m_prev;
      m_prev = viol_req;
      if (m_mode == 0) begin
         if (ev != 0) begin
            m_cause = ev;
            m_to    = 1'b0;
            m_new_pulse();
         end
      end else if (m_mode == 1) begin
         m_cause = m_cause | ev;
         if (m_high == HOLD) begin
            m_mode   = 2;
            m_waited = 1;
         end else begin
            m_high++;
         end
      end else begin
         if (ev != 0) begin
            m_cause = m_cause | ev;
            m_new_pulse();
         end else if (pc == RH) begin
            m_mode = 0;
         end else if (m_waited == WT) begin
            m_to = 1'b1;
            m_new_pulse();
         end else begin
            m_waited++;
         end
      end
   endtask

   // ---------------- checking helpers ----------------
   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] dut_vec();
      return {17'd0, sys_rst, busy, rst_cause, rst_timeout, viol_cnt};
   endfunction

   function automatic logic [31:0] model_vec();
      logic ms, mb;
      ms = (m_mode == 1);
      mb = (m_mode != 0);
      return {17'd0, ms, mb, m_cause, m_to, 8'(m_cnt)};
   endfunction

   // One clock: inputs are already stable, model follows the edge, outputs
   // are sampled 1 ns later and new inputs may be driven from then on.
   task automatic step();
      @(posedge clk);
      model_step();
      #1;
      check("model", dut_vec(), model_vec());
   endtask

   task automatic do_reset();
      reset = 1'b1; viol_req = '0; pc = PC0;
      step();
      reset = 1'b0;
   endtask

   // ---------------- vector table ----------------
   typedef struct {
      logic            rst;
      logic [NREQ-1:0] viol;
      logic [15:0]     pcv;
      logic            e_srst;
      logic            e_busy;
      logic [NREQ-1:0] e_cause;
      logic            e_to;
      logic [7:0]      e_cnt;
   } vec_t;

   vec_t tbl[16];

   function automatic vec_t mk(input logic r, input logic [3:0] v, input logic [15:0] p,
                               input logic s, input logic b, input logic [3:0] c,
                               input logic t, input logic [7:0] n);
      vec_t x;
      x.rst = r; x.viol = v; x.pcv = p; x.e_srst = s; x.e_busy = b;
      x.e_cause = c; x.e_to = t; x.e_cnt = n;
      return x;
   endfunction

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int high;
      reset = 1'b1; viol_req = '0; pc = PC0;

      //            rst viol   pc     srst busy cause  to cnt
      tbl[0]  = mk(1, 4'h0, PC0, 0, 0, 4'h0, 0, 8'd0);
      tbl[1]  = mk(0, 4'h2, PC0, 1, 1, 4'h2, 0, 8'd1);
      tbl[2]  = mk(0, 4'h0, PC0, 1, 1, 4'h2, 0, 8'd1);
      tbl[3]  = mk(0, 4'h4, PC0, 1, 1, 4'h6, 0, 8'd1);
      tbl[4]  = mk(0, 4'h4, PC0, 1, 1, 4'h6, 0, 8'd1);
      tbl[5]  = mk(0, 4'h0, RH,  1, 1, 4'h6, 0, 8'd1);
      tbl[6]  = mk(0, 4'h0, PC0, 1, 1, 4'h6, 0, 8'd1);
      tbl[7]  = mk(0, 4'h0, PC0, 1, 1, 4'h6, 0, 8'd1);
      tbl[8]  = mk(0, 4'h0, PC0, 1, 1, 4'h6, 0, 8'd1);
      tbl[9]  = mk(0, 4'h0, PC0, 0, 1, 4'h6, 0, 8'd1);
      tbl[10] = mk(0, 4'h0, RH,  0, 0, 4'h6, 0, 8'd1);
      tbl[11] = mk(1, 4'h0, PC0, 0, 0, 4'h0, 0, 8'd0);
      tbl[12] = mk(0, 4'h1, PC0, 1, 1, 4'h1, 0, 8'd1);
      tbl[13] = mk(1, 4'h1, PC0, 0, 0, 4'h0, 0, 8'd0);
      tbl[14] = mk(0, 4'h1, PC0, 1, 1, 4'h1, 0, 8'd1);
      tbl[15] = mk(1, 4'h0, PC0, 0, 0, 4'h0, 0, 8'd0);

      for (int i = 0; i < 16; i++) begin
         reset = tbl[i].rst; viol_req = tbl[i].viol; pc = tbl[i].pcv;
         step();
         check($sformatf("tbl[%0d]", i), dut_vec(),
               {17'd0, tbl[i].e_srst, tbl[i].e_busy, tbl[i].e_cause, tbl[i].e_to, tbl[i].e_cnt});
      end

      // Held level on bit0, no vector fetch: pulse, timeout, second pulse.
      do_reset();
      high = 0;
      pc = 16'h0000; viol_req = 4'b0001;
      for (int i = 1; i <= 272; i++) begin
         if (i == 21) viol_req = 4'b0000;
         step();
         high += int'(sys_rst);
         if (i == 8)   check("held_first_pulse_cnt", {31'd0, sys_rst}, 32'd1);
         if (i == 9)   check("held_cause", {28'd0, rst_cause}, 32'h1);
         if (i == 264) check("held_before_to", {23'd0, rst_timeout, viol_cnt}, {23'd0, 1'b0, 8'd1});
         if (i == 265) check("held_after_to", {22'd0, sys_rst, rst_timeout, viol_cnt}, {22'd0, 1'b1, 1'b1, 8'd2});
      end
      check("held_high_cycles", 32'(high), 32'd16);
      step();
      check("held_second_end", {31'd0, sys_rst}, 32'd0);

      // Single-cycle pulse on bit1, vector fetch 3 cycles after sys_rst falls.
      do_reset();
      viol_req = 4'b0010; step();
      viol_req = 4'b0000;
      repeat (8) step();
      check("fetch_srst_low", {30'd0, sys_rst, busy}, 32'b01);
      repeat (2) step();
      pc = RH; step();
      check("fetch_idle", {26'd0, busy, rst_cause, rst_timeout}, {26'd0, 1'b0, 4'b0010, 1'b0});
      pc = PC0;

      // bit2 rises during the 4th pulse cycle: pulse stays 8 long.
      do_reset();
      high = 0;
      viol_req = 4'b0010; step(); high += int'(sys_rst);
      viol_req = 4'b0000; step(); high += int'(sys_rst);
      step(); high += int'(sys_rst);
      viol_req = 4'b0100; step(); high += int'(sys_rst);
      viol_req = 4'b0000;
      repeat (8) begin step(); high += int'(sys_rst); end
      check("late_pulse_len", 32'(high), 32'd8);
      check("late_cause_cnt", {20'd0, rst_cause, viol_cnt}, {20'd0, 4'b0110, 8'd1});
      pc = RH; step(); pc = PC0;

      // bit3 rises while waiting in the same cycle the vector is fetched.
      do_reset();
      viol_req = 4'b0001; step();
      viol_req = 4'b0000;
      repeat (8) step();
      viol_req = 4'b1000; pc = RH; step();
      check("prio_reassert", {19'd0, sys_rst, rst_cause, viol_cnt}, {19'd0, 1'b1, 4'b1001, 8'd2});
      high = 1;
      viol_req = 4'b0000; pc = PC0;
      repeat (10) begin step(); high += int'(sys_rst); end
      check("prio_pulse_len", 32'(high), 32'd8);
      pc = RH; step(); pc = PC0;

      // 300 episodes: the counter saturates.
      do_reset();
      for (int e = 0; e < 300; e++) begin
         viol_req = 4'b0100; step();
         viol_req = 4'b0000;
         repeat (8) step();
         pc = RH; step(); pc = PC0;
         if (e == 254) check("sat_255", {24'd0, viol_cnt}, 32'd255);
      end
      check("sat_final", {31'd0, busy, viol_cnt}, {23'd0, 1'b0, 8'hFF});

      // Reset in pulse cycle 3 while bit0 is held high.
      do_reset();
      viol_req = 4'b0001;
      repeat (3) step();
      check("abort_pre", {31'd0, sys_rst}, 32'd1);
      reset = 1'b1; step();
      check("abort_zero", dut_vec(), 32'd0);
      reset = 1'b0; step();
      check("abort_restart", {22'd0, sys_rst, busy, viol_cnt}, {22'd0, 1'b1, 1'b1, 8'd1});
      viol_req = 4'b0000;

      // Randomised traffic against the model.
      do_reset();
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 7) == 0) viol_req[$urandom_range(0, NREQ-1)] ^= 1'b1;
         pc = ($urandom_range(0, 15) == 0) ? RH : 16'($urandom);
         reset = ($urandom_range(0, 499) == 0);
         step();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
